// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output stage.
//   - Default 640x480@60 timing values used as parameter defaults.
//   - RGB332 field positions within the object-mux pixel byte.
//   - Raw sync/active bundle carried through the alignment delay line.
//   - Colour-expansion helpers (bit replication to 8-bit channels).
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned H_FP_DEF       = 16;
   localparam int unsigned H_SYNC_DEF     = 96;
   localparam int unsigned H_BP_DEF       = 48;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned V_FP_DEF       = 10;
   localparam int unsigned V_SYNC_DEF     = 2;
   localparam int unsigned V_BP_DEF       = 33;
   localparam int unsigned PIPE_DEPTH_DEF = 2;

   localparam int unsigned CNT_W   = 11;
   localparam int unsigned CNT_MAX = 2047;

   // RGB332: R[7:5], G[4:2], B[1:0]
   localparam int unsigned R_MSB = 7;
   localparam int unsigned R_LSB = 5;
   localparam int unsigned G_MSB = 4;
   localparam int unsigned G_LSB = 2;
   localparam int unsigned B_MSB = 1;
   localparam int unsigned B_LSB = 0;

   // Raw flags are active-high; all-zero is the idle (blank, no sync) state.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } sync_bundle_t;

   function automatic logic [7:0] expand3(input logic [2:0] c);
      return {c, c, c[2:1]};
   endfunction

   function automatic logic [7:0] expand2(input logic [1:0] c);
      return {c, c, c, c};
   endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Parameterised shift register used to align control flags with the
// pixel data returning from the drawing pipeline.
//   clk   : pixel clock
//   reset : synchronous active-high, clears every stage to all-zero
//   din   : WIDTH-bit input word
//   dout  : din delayed by DEPTH cycles (DEPTH==0 gives a wire)
module sig_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stages [DEPTH];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
            end else begin
               stages[0] <= din;
               for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
         end

         assign dout = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// VGA timing generator and output register stage.
//   clk          : pixel clock
//   reset        : synchronous active-high reset
//   RGBIn        : RGB332 pixel from the object mux, PIPE_DEPTH cycles
//                  behind pixelX/pixelY
//   pixelX/Y     : current counters, fed to the drawing units
//   startOfFrame : one-cycle pulse while the counters are at (0,0)
//   VGA_HS/VS    : active-low syncs, aligned with the colour outputs
//   VGA_BLANK_N  : high while the aligned position is visible
//   VGA_R/G/B    : 8-bit channels expanded from RGB332, zero when blank
module vga_out_stage
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  RGBIn,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
         $error("vga_out_stage: H_TOTAL or V_TOTAL exceeds the 11-bit counter range");
      end
   endgenerate

   logic [CNT_W-1:0] hcnt, vcnt;
   logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
   logic             run_q;
   logic             sof_q;

   always_comb begin
      hcnt_nxt = hcnt + 1'b1;
      vcnt_nxt = vcnt;
      if (hcnt == H_LAST) begin
         hcnt_nxt = '0;
         vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end
   end

   // The first clock after reset releases holds the counters at (0,0) so
   // that cycle presents the frame start (startOfFrame=1) while the reset
   // cycle itself still shows startOfFrame=0.
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt  <= '0;
         vcnt  <= '0;
         run_q <= 1'b0;
         sof_q <= 1'b0;
      end else if (!run_q) begin
         run_q <= 1'b1;
         sof_q <= 1'b1;
      end else begin
         hcnt  <= hcnt_nxt;
         vcnt  <= vcnt_nxt;
         sof_q <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
      end
   end

   assign pixelX       = hcnt;
   assign pixelY       = vcnt;
   assign startOfFrame = sof_q;

   // Raw flags are forced idle while the counters are parked in reset, so
   // the delay line only ever carries positions that actually get drawn.
   sync_bundle_t raw, dly;

   always_comb begin
      raw = '0;
      if (run_q) begin
         raw.hsync  = (hcnt >= HS_START) && (hcnt < HS_END);
         raw.vsync  = (vcnt >= VS_START) && (vcnt < VS_END);
         raw.active = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
      end
   end

   sig_delay_line #(
      .WIDTH ($bits(sync_bundle_t)),
      .DEPTH (PIPE_DEPTH)
   ) u_flag_delay (
      .clk   (clk),
      .reset (reset),
      .din   (raw),
      .dout  (dly)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         VGA_HS      <= ~dly.hsync;
         VGA_VS      <= ~dly.vsync;
         VGA_BLANK_N <= dly.active;
         if (dly.active) begin
            VGA_R <= expand3(RGBIn[R_MSB:R_LSB]);
            VGA_G <= expand3(RGBIn[G_MSB:G_LSB]);
            VGA_B <= expand2(RGBIn[B_MSB:B_LSB]);
         end else begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
         end
      end
   end

endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 Parameters SHALL be:
- H_ACTIVE, default 640, visible pixels per line.
- H_FP, default 16, horizontal front porch.
- H_SYNC, default 96, horizontal sync width.
- H_BP, default 48, horizontal back porch.
- V_ACTIVE, default 480, visible lines.
- V_FP, default 10, vertical front porch.
- V_SYNC, default 2, vertical sync width.
- V_BP, default 33, vertical back porch.
- PIPE_DEPTH, default 2, cycles from pixelX/pixelY to the RGB arriving at RGBIn.
REQ-002 Ports SHALL be:
- clk, in, 1, pixel clock; the one and only clock.
- reset, in, 1, synchronous active-high reset.
- RGBIn, in, 8, RGB332 pixel from the object mux: R[7:5], G[4:2], B[1:0].
- pixelX, out, 11, current horizontal counter, fed to the drawing units.
- pixelY, out, 11, current vertical counter, fed to the drawing units.
- startOfFrame, out, 1, one-cycle pulse at the start of each frame.
- VGA_HS, out, 1, horizontal sync, active low.
- VGA_VS, out, 1, vertical sync, active low.
- VGA_BLANK_N, out, 1, high while the delayed position is in the active area.
- VGA_R, out, 8, red channel.
- VGA_G, out, 8, green channel.
- VGA_B, out, 8, blue channel.

Function
REQ-003 hcnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), and wrap to 0.
REQ-004 vcnt SHALL increment only when hcnt wraps, count 0..V_TOTAL-1 (525), and wrap to 0 when hcnt and vcnt wrap together.
REQ-005 pixelX SHALL equal hcnt and pixelY SHALL equal vcnt in the same cycle, driven straight from the counter registers.
REQ-006 startOfFrame SHALL be 1 for exactly the one cycle where hcnt==0 and vcnt==0, and 0 otherwise.
REQ-007 hsync_raw SHALL be asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-008 vsync_raw SHALL be asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-009 active_raw SHALL equal (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
REQ-010 hsync_raw, vsync_raw and active_raw SHALL pass through a PIPE_DEPTH-stage shift register.
REQ-011 The final output register SHALL add one more cycle, so a change on RGBIn at cycle t appears on VGA_R/G/B at cycle t+1, aligned with the delayed sync and active flags.
REQ-012 VGA_HS SHALL be the inverse of the delayed hsync_raw, and VGA_VS the inverse of the delayed vsync_raw.
REQ-013 VGA_BLANK_N SHALL be the delayed active_raw.
REQ-014 Colour expansion SHALL replicate bits:
- VGA_R = {R,R,R[2:1]}.
- VGA_G = {G,G,G[2:1]}.
- VGA_B = {B,B,B,B}.
REQ-015 VGA_R/G/B SHALL be 8'h00 whenever the delayed active flag is 0, whatever RGBIn holds.
REQ-016 All outputs SHALL be registered; no combinational path SHALL exist from RGBIn to any output.
REQ-017 Counter widths SHALL be 11 bits; any parameter set giving H_TOTAL or V_TOTAL above 2047 is illegal and SHALL fail elaboration.

Reset
REQ-018 While reset is high at a rising clk, the block SHALL load:
- hcnt=0, vcnt=0.
- All delay stages with sync inactive and active=0.
- VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
- startOfFrame=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame at once; the first cycle after release SHALL give hcnt=0, vcnt=0 and startOfFrame=1.
REQ-020 During the first PIPE_DEPTH+1 cycles after reset, the outputs SHALL show only the reset-loaded pipeline contents: blank, syncs high.

Structure
REQ-021 The timing parameters' default values and the RGB332 field-position constants SHALL live in shared package vga_pkg.
REQ-022 The delay line SHALL be one parameterised sub-module, sig_delay_line (WIDTH, DEPTH), instantiated once for the {hsync, vsync, active} bundle.
REQ-023 The counters, sync decode and colour expansion SHALL stay in vga_out_stage.

Verification
REQ-024 Reset for 3 cycles, then run 2 frames -> startOfFrame pulses exactly 1 cycle at 0 and again at 420000 cycles after release.
REQ-025 One full line -> VGA_HS low for exactly 96 consecutive cycles, with its first low cycle 656+PIPE_DEPTH+1 cycles after hcnt==0.
REQ-026 One full frame -> VGA_VS low for exactly 2 lines (1600 cycles), starting at line 490 plus the pipeline offset.
REQ-027 RGBIn=8'hFF during active area -> VGA_R/G/B=8'hFF; RGBIn=8'b101_010_01 -> VGA_R=8'hB6, VGA_G=8'h49, VGA_B=8'h55.
REQ-028 RGBIn=8'hFF held constant across the blanking interval -> VGA_R/G/B=8'h00 wherever VGA_BLANK_N=0.
REQ-029 Assert reset at pixelX=300, pixelY=200 for 1 cycle -> next cycle pixelX=0, pixelY=0, startOfFrame=1, and VGA_BLANK_N stays 0 for PIPE_DEPTH+1 cycles.
